// File: rtl/uni_shift_sequencer.sv
// Command sequencer for the SchemaUNI 8-bit universal shift register:
// one parallel load followed by N shift-up, shift-down or rotate-up steps.
module uni_shift_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [7:0]       din,
    input  logic             fill,
    input  logic [CNT_W-1:0] count,
    input  logic [7:0]       q_fb,
    output logic             A1,
    output logic             A0,
    output logic [7:0]       D,
    output logic             DL,
    output logic             DR,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       op_r;
    logic [7:0]       din_r;
    logic             fill_r;
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            op_r      <= '0;
            din_r     <= '0;
            fill_r    <= 1'b0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                op_r      <= op;
                din_r     <= din;
                fill_r    <= fill;
                remaining <= count;
            end
            if (state == SHIFT) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    // D is driven from the latched byte in every state; it is only sampled
    // by SchemaUNI in LOAD (mode 11), so this keeps the bus quiet and simple.
    always_comb begin
        state_next = state;
        A1         = 1'b0;
        A0         = 1'b0;
        D          = din_r;
        DL         = 1'b0;
        DR         = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                A1 = 1'b1;
                A0 = 1'b1;
                if (op_r == 2'b00 || remaining == '0) begin
                    state_next = DONE;
                end else begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                case (op_r)
                    2'b01: begin
                        A0 = 1'b1;
                        DR = fill_r;
                    end
                    2'b10: begin
                        A1 = 1'b1;
                        DL = fill_r;
                    end
                    2'b11: begin
                        // rotate: Q7 wraps straight back into the shift-up input
                        A0 = 1'b1;
                        DR = q_fb[7];
                    end
                    default: ;
                endcase
                if (remaining == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
